// File: rtl/int_alu_pkg.sv
// Shared definitions for the integer ALU blocks: default multiplier geometry
// and the tag that travels alongside each multiply through the pipeline.
package int_alu_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int LATENCY_DEF    = 5;
   localparam int FIFO_DEPTH_DEF = 8;

   typedef struct packed {
      logic valid;
      logic neg;
   } mult_tag_t;

   // Width of a counter that must represent 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/int_mult_result_fifo.sv
// Result FIFO behind int_mult: power-of-two storage with wrapping pointers
// and an occupancy count; simultaneous write and read are always honoured.
module int_mult_result_fifo
   import int_alu_pkg::*;
#(
   parameter int WIDTH = 2 * DATA_WIDTH_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_rd;
   logic             full;

   assign valid   = (count != '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_rd   = rd_en && valid;
   assign rd_data = mem[rd_ptr];

   // NOTE: storage has no reset; only pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, do_rd})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Credits upstream make this unreachable; a hit means the credit loop is broken.
   assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full && !do_rd))
      else $error("int_mult_result_fifo: write to full FIFO");

endmodule

// File: rtl/int_mult_result_queue.sv
// Credit-based result queue for a never-stalling int_mult: tracks each accepted
// op through a tag pipe, applies optional negation and buffers products in order.
module int_mult_result_queue
   import int_alu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LATENCY    = LATENCY_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic                    in_neg,
   output logic                    in_ready,
   output logic                    mult_en,
   input  logic [2*DATA_WIDTH-1:0] mult_result,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out_data,
   output logic                    busy
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int CW = count_width(FIFO_DEPTH);

   logic [CW-1:0] credits;
   mult_tag_t     tag_pipe [LATENCY];
   mult_tag_t     tag_last;
   logic          accept;
   logic          pop;
   logic          any_tag_valid;
   logic [PW-1:0] wr_data;

   assign accept   = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign in_ready = (credits != '0);
   assign mult_en  = rst_n;

   // A credit covers an op from accept until its result leaves the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= CW'(FIFO_DEPTH);
      end else if (accept && !pop) begin
         credits <= credits - CW'(1);
      end else if (pop && !accept) begin
         credits <= credits + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= '{valid: accept, neg: in_neg};
         for (int i = 1; i < LATENCY; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   // NOTE: assign a default before the loop so the OR-reduce cannot infer a latch.
   always_comb begin
      any_tag_valid = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         any_tag_valid = any_tag_valid | tag_pipe[i].valid;
      end
   end

   assign tag_last = tag_pipe[LATENCY-1];
   assign wr_data  = tag_last.neg ? (PW'(0) - mult_result) : mult_result;
   assign busy     = any_tag_valid || out_valid;

   int_mult_result_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tag_last.valid),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (out_data),
      .valid   (out_valid)
   );

endmodule

// File: tb/tb_int_mult_result_queue.sv
// Randomised and directed bench for int_mult_result_queue against an
// order-preserving queue model with per-op availability times.
module tb_int_mult_result_queue;

   localparam int DW = 32;
   localparam int L  = 5;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_neg = 1'b0;
   logic          in_ready;
   logic          mult_en;
   logic [63:0]   mult_result;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [63:0]   out_data;
   logic          busy;
   logic [DW-1:0] op_a = '0;
   logic [DW-1:0] op_b = '0;

   int_mult_result_queue #(
      .DATA_WIDTH (DW),
      .LATENCY    (L),
      .FIFO_DEPTH (D)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_neg      (in_neg),
      .in_ready    (in_ready),
      .mult_en     (mult_en),
      .mult_result (mult_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Stand-in for int_mult: an L-edge product delay line that advances while enabled.
   logic [63:0] mult_pipe [L];
   always @(posedge clk) begin
      if (mult_en) begin
         mult_pipe[0] <= {32'b0, op_a} * {32'b0, op_b};
         for (int i = 1; i < L; i++) mult_pipe[i] <= mult_pipe[i-1];
      end
   end
   assign mult_result = mult_pipe[L-1];

   typedef struct {
      logic [63:0] val;
      int          ready_edge;
   } exp_t;

   exp_t        exp_q[$];
   int          next_edge = 1;
   int          vectors = 0;
   int          miscompares = 0;
   int          dut_accepts = 0;
   int          dut_stalls = 0;
   int          seen_valid = 0;
   logic [63:0] last_pop = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge: check outputs, drive inputs for the next rising edge,
   // advance the model to that edge, and wait for the following falling edge.
   task automatic step(input logic v, input logic n, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy);
      logic        exp_vld;
      logic        exp_rdy;
      logic [63:0] prod;
      exp_t        e;
      exp_vld = (exp_q.size() != 0) && (exp_q[0].ready_edge <= next_edge - 1);
      exp_rdy = (exp_q.size() < D);
      check("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
      check("out_valid", {63'b0, out_valid}, {63'b0, exp_vld});
      check("busy", {63'b0, busy}, {63'b0, exp_q.size() != 0});
      check("mult_en", {63'b0, mult_en}, 64'd1);
      if (exp_vld) check("out_data", out_data, exp_q[0].val);
      if (v && in_ready) dut_accepts++;
      if (!in_ready) dut_stalls++;
      if (out_valid) seen_valid++;
      if (rdy && out_valid) last_pop = out_data;
      in_valid  = v;
      in_neg    = n;
      op_a      = a;
      op_b      = b;
      out_ready = rdy;
      if (exp_vld && rdy) exp_q.delete(0);
      if (v && exp_rdy) begin
         prod         = {32'b0, a} * {32'b0, b};
         e.val        = n ? -prod : prod;
         e.ready_edge = next_edge + L;
         exp_q.push_back(e);
      end
      next_edge++;
      @(negedge clk);
   endtask

   task automatic idle(input int cycles, input logic rdy);
      repeat (cycles) step(1'b0, 1'b0, $urandom, $urandom, rdy);
   endtask

   task automatic do_reset(input int cycles);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_mult_en", {63'b0, mult_en}, 64'd0);
      check("rst_in_ready", {63'b0, in_ready}, 64'd1);
      exp_q.delete();
      repeat (cycles) @(negedge clk);
      rst_n     = 1'b1;
      next_edge = 1;
   endtask

   function automatic logic [31:0] rand_op();
      return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      do_reset(3);

      // 3x7 accepted at edge 10, popped immediately when it appears.
      idle(9, 1'b1);
      step(1'b1, 1'b0, 32'd3, 32'd7, 1'b1);
      idle(8, 1'b1);
      check("mul_3x7", last_pop, 64'd21);

      step(1'b1, 1'b1, 32'd5, 32'd6, 1'b1);
      idle(8, 1'b1);
      check("neg_5x6", last_pop, 64'hFFFF_FFFF_FFFF_FFE2);

      // Stall the consumer: exactly D accepts, then drain in order.
      dut_accepts = 0;
      repeat (12) step(1'b1, 1'($urandom_range(0, 1)), rand_op(), rand_op(), 1'b0);
      check("stall_accepts", 64'(dut_accepts), 64'd8);
      check("stall_in_ready", {63'b0, in_ready}, 64'd0);
      idle(15, 1'b1);

      // Back-to-back with a free consumer must never lose in_ready.
      dut_stalls = 0;
      repeat (20) step(1'b1, 1'($urandom_range(0, 1)), rand_op(), rand_op(), 1'b1);
      check("b2b_stalls", 64'(dut_stalls), 64'd0);
      idle(10, 1'b1);

      // Fill the FIFO, then pop while new results keep landing.
      repeat (8) step(1'b1, 1'($urandom_range(0, 1)), rand_op(), rand_op(), 1'b0);
      idle(6, 1'b0);
      repeat (16) step(1'b1, 1'($urandom_range(0, 1)), rand_op(), rand_op(), 1'b1);
      idle(12, 1'b1);

      // Reset with two ops queued and three in flight: nothing may survive.
      repeat (2) step(1'b1, 1'b0, rand_op(), rand_op(), 1'b0);
      idle(6, 1'b0);
      repeat (3) step(1'b1, 1'b1, rand_op(), rand_op(), 1'b0);
      do_reset(2);
      seen_valid = 0;
      idle(10, 1'b1);
      check("stale_results", 64'(seen_valid), 64'd0);

      // Randomised traffic with random consumer backpressure.
      repeat (300) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        rand_op(), rand_op(), 1'($urandom_range(0, 3) != 0));
      idle(20, 1'b1);
      check("final_empty", {63'b0, out_valid}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
